// File: rtl/mips_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, requester indices
// and the read-data pattern returned on an aborted access.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_EXT = 1'b1;

    localparam logic [31:0] ABORT_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester always wins, a tie goes to the
// port that was not granted last.
module rr_pick2
    import mips_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    always_comb begin
        o_grant_valid = |i_req;
        o_grant_idx   = PORT_CPU;
        case (i_req)
            2'b01:   o_grant_idx = PORT_CPU;
            2'b10:   o_grant_idx = PORT_EXT;
            2'b11:   o_grant_idx = ~i_last_grant;
            default: o_grant_idx = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the
// loader/debug port (port 1). Define ARB_TIMEOUT_EN to abort stalled accesses.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,

    output logic          err
);

    arb_state_t    r_state;
    logic          r_last_grant;
    logic          r_gnt_idx;
    logic          r_cpu_ack;
    logic          r_ext_ack;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ext_rdata;

    logic [1:0]    w_req;
    logic          w_grant_valid;
    logic          w_grant_idx;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_timeout;
    logic          w_done;
    logic [DW-1:0] w_done_rdata;

    assign w_req = {ext_req, cpu_req};

    rr_pick2 u_pick (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_sel_we    = (w_grant_idx == PORT_EXT) ? ext_we    : cpu_we;
    assign w_sel_addr  = (w_grant_idx == PORT_EXT) ? ext_addr  : cpu_addr;
    assign w_sel_wdata = (w_grant_idx == PORT_EXT) ? ext_wdata : cpu_wdata;

    // A real completion always beats an abort landing on the same edge.
    assign w_done       = mem_ready | w_timeout;
    assign w_done_rdata = mem_ready ? mem_rdata : DW'(ABORT_WORD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_EXT;
            r_gnt_idx    <= PORT_CPU;
            r_cpu_ack    <= 1'b0;
            r_ext_ack    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_ext_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_mem_we     <= w_sel_we;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_mem_req    <= 1'b1;
                        r_last_grant <= w_grant_idx;
                        r_gnt_idx    <= w_grant_idx;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ACK;
                        if (r_gnt_idx == PORT_EXT) begin
                            r_ext_rdata <= w_done_rdata;
                            r_ext_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= w_done_rdata;
                            r_cpu_ack   <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_err;

    assign w_timeout = ~mem_ready & (r_wait == 8'(TIMEOUT - 1));

    // Counts ACCESS cycles spent without mem_ready; err tracks the ack pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_grant_valid) begin
                r_wait <= 8'd0;
            end else if (r_state == ACCESS && !mem_ready) begin
                r_wait <= r_wait + 8'd1;
            end
            if (r_state == ACCESS && w_done) begin
                r_err <= ~mem_ready;
            end else if (r_state == ACK) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT;
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    assign cpu_ack   = r_cpu_ack;
    assign ext_ack   = r_ext_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ext_rdata = r_ext_rdata;
    assign cpu_stall = cpu_req & ~r_cpu_ack;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level model.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_ack;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        mem_req, mem_we, mem_ready, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        ereq;
        logic        ewe;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [31:0] rdata;
        logic        exp_port;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[7];

    // Transaction-level reference model state
    int          m_ack;
    bit          m_busy;
    bit          m_err;
    int          m_owner, m_last, m_wait;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rd[2];

    initial begin
        logic [31:0] exp_crd, exp_erd;
        int cyc;

        tbl[0] = '{1, 1, 32'h20, 32'hAAAA0001, 1, 1, 32'h24, 32'hBBBB0002, 32'h11111111, 0, 32'h20, 1, 32'hAAAA0001};
        tbl[1] = '{1, 1, 32'h20, 32'hAAAA0001, 1, 1, 32'h24, 32'hBBBB0002, 32'h22222222, 1, 32'h24, 1, 32'hBBBB0002};
        tbl[2] = '{1, 1, 32'h20, 32'hAAAA0001, 1, 1, 32'h24, 32'hBBBB0002, 32'h33333333, 0, 32'h20, 1, 32'hAAAA0001};
        tbl[3] = '{0, 0, 32'h00, 32'h00000000, 1, 0, 32'h30, 32'h00000000, 32'h5A5A5A5A, 1, 32'h30, 0, 32'h00000000};
        tbl[4] = '{1, 0, 32'h14, 32'h00000000, 1, 1, 32'h34, 32'hCCCC0003, 32'h44444444, 0, 32'h14, 0, 32'h00000000};
        tbl[5] = '{1, 0, 32'h10, 32'h00000000, 0, 0, 32'h00, 32'h00000000, 32'h12345678, 0, 32'h10, 0, 32'h00000000};
        tbl[6] = '{1, 1, 32'h18, 32'hDDDD0004, 1, 0, 32'h38, 32'h00000000, 32'h66666666, 1, 32'h38, 0, 32'h00000000};

        // Reset values
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst cpu_ack", cpu_ack, 0);
        check("rst ext_ack", ext_ack, 0);
        check("rst cpu_rdata", cpu_rdata, 0);
        check("rst ext_rdata", ext_rdata, 0);
        check("rst err", err, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait vector table; consecutive ties alternate
        exp_crd = 0;
        exp_erd = 0;
        for (int i = 0; i < 7; i++) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwdata;
            ext_req = tbl[i].ereq; ext_we = tbl[i].ewe; ext_addr = tbl[i].eaddr; ext_wdata = tbl[i].ewdata;
            mem_ready = 1'b1;
            mem_rdata = tbl[i].rdata;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d mem_req", i), mem_req, 1);
            check($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].exp_addr);
            check($sformatf("vec%0d mem_we", i), mem_we, tbl[i].exp_we);
            check($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].exp_wdata);
            check($sformatf("vec%0d early acks", i), {cpu_ack, ext_ack}, 0);
            check($sformatf("vec%0d stall access", i), cpu_stall, tbl[i].creq);
            @(posedge clk);
            @(negedge clk);
            if (tbl[i].exp_port == 1'b0) exp_crd = tbl[i].rdata;
            else exp_erd = tbl[i].rdata;
            check($sformatf("vec%0d mem_req ack", i), mem_req, 0);
            check($sformatf("vec%0d cpu_ack", i), cpu_ack, tbl[i].exp_port == 1'b0);
            check($sformatf("vec%0d ext_ack", i), ext_ack, tbl[i].exp_port == 1'b1);
            check($sformatf("vec%0d cpu_rdata", i), cpu_rdata, exp_crd);
            check($sformatf("vec%0d ext_rdata", i), ext_rdata, exp_erd);
            check($sformatf("vec%0d stall ack", i), cpu_stall, tbl[i].creq & (tbl[i].exp_port == 1'b1));
            check($sformatf("vec%0d err", i), err, 0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(posedge clk);
        #1;

        // External write against a memory that takes 6 cycles; core waits behind it
        ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("slow mem_req c%0d", k), mem_req, 1);
            check($sformatf("slow mem_addr c%0d", k), mem_addr, 32'h40);
            check($sformatf("slow mem_wdata c%0d", k), mem_wdata, 32'hCAFEF00D);
            check($sformatf("slow ext_ack c%0d", k), ext_ack, 0);
            check($sformatf("slow stall c%0d", k), cpu_stall, 1);
            ext_addr = ext_addr ^ 32'h0000_0FF0;
            ext_wdata = ~ext_wdata;
            if (k == 5) begin
                mem_ready = 1;
                mem_rdata = 32'h0BADF00D;
            end
        end
        @(negedge clk);
        check("slow ext_ack", ext_ack, 1);
        check("slow mem_req drop", mem_req, 0);
        check("slow cpu_ack", cpu_ack, 0);
        check("slow stall at ext ack", cpu_stall, 1);
        ext_req = 0;
        mem_rdata = 32'h87654321;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("after slow mem_addr", mem_addr, 32'h44);
        check("after slow stall", cpu_stall, 1);
        @(negedge clk);
        check("after slow cpu_ack", cpu_ack, 1);
        check("after slow cpu_rdata", cpu_rdata, 32'h87654321);
        check("after slow stall ack", cpu_stall, 0);
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset during ACCESS and during ACK, then a tie must go to the core
        cpu_req = 1; cpu_addr = 32'h50;
        @(posedge clk);
        @(negedge clk);
        check("rstmid mem_req before", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rstmid mem_req async", mem_req, 0);
        check("rstmid mem_addr async", mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1; mem_rdata = 32'h5555AAAA;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rstack cpu_ack before", cpu_ack, 1);
        #2 rst = 1'b0;
        #1;
        check("rstack cpu_ack async", cpu_ack, 0);
        check("rstack cpu_rdata async", cpu_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1; cpu_addr = 32'h60; ext_req = 1; ext_addr = 32'h64;
        @(posedge clk);
        @(negedge clk);
        check("rst tie mem_addr", mem_addr, 32'h60);
        @(negedge clk);
        check("rst tie cpu_ack", cpu_ack, 1);
        check("rst tie ext_ack", ext_ack, 0);
        idle_inputs();
        @(posedge clk);
        #1;

        // Memory that never answers
        cpu_req = 1; cpu_addr = 32'h70;
        @(posedge clk);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mem_req) break;
            cyc++;
        end
`ifdef ARB_TIMEOUT_EN
        check("timeout access cycles", cyc, TIMEOUT);
        check("timeout cpu_ack", cpu_ack, 1);
        check("timeout err", err, 1);
        check("timeout cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        idle_inputs();
        @(posedge clk);
        #1;
        // Ready in the last allowed cycle wins over the abort
        cpu_req = 1; cpu_addr = 32'h74;
        @(posedge clk);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            check($sformatf("late mem_req c%0d", k), mem_req, 1);
            if (k == TIMEOUT - 1) begin
                mem_ready = 1;
                mem_rdata = 32'h13579BDF;
            end
        end
        @(negedge clk);
        check("late cpu_ack", cpu_ack, 1);
        check("late err", err, 0);
        check("late cpu_rdata", cpu_rdata, 32'h13579BDF);
`else
        check("no-timeout still waiting", cyc, 40);
        mem_ready = 1;
        mem_rdata = 32'h13579BDF;
        @(negedge clk);
        check("no-timeout cpu_ack", cpu_ack, 1);
        check("no-timeout err", err, 0);
        check("no-timeout cpu_rdata", cpu_rdata, 32'h13579BDF);
`endif
        idle_inputs();
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        do_reset();
        m_ack = -1; m_busy = 0; m_err = 0; m_owner = 0; m_last = 1; m_wait = 0;
        m_we = 0; m_addr = 0; m_wdata = 0; m_rd[0] = 0; m_rd[1] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            check("rnd mem_req", mem_req, m_busy);
            check("rnd mem_addr", mem_addr, m_addr);
            check("rnd mem_we", mem_we, m_we);
            check("rnd mem_wdata", mem_wdata, m_wdata);
            check("rnd cpu_ack", cpu_ack, m_ack == 0);
            check("rnd ext_ack", ext_ack, m_ack == 1);
            check("rnd cpu_rdata", cpu_rdata, m_rd[0]);
            check("rnd ext_rdata", ext_rdata, m_rd[1]);
            check("rnd err", err, (m_ack >= 0) && m_err);
            check("rnd cpu_stall", cpu_stall, cpu_req && (m_ack != 0));
            cpu_req   = ($urandom % 4) != 0;
            cpu_we    = $urandom % 2;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            ext_req   = ($urandom % 3) == 0;
            ext_we    = $urandom % 2;
            ext_addr  = $urandom;
            ext_wdata = $urandom;
            mem_ready = ($urandom % 3) == 0;
            mem_rdata = $urandom;
            @(posedge clk);
            if (m_ack >= 0) begin
                m_ack = -1;
            end else if (m_busy) begin
                if (mem_ready) begin
                    m_rd[m_owner] = mem_rdata;
                    m_ack = m_owner;
                    m_err = 0;
                    m_busy = 0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_wait == TIMEOUT - 1) begin
                    m_rd[m_owner] = 32'hDEADBEEF;
                    m_ack = m_owner;
                    m_err = 1;
                    m_busy = 0;
                end else begin
                    m_wait++;
                end
`endif
            end else if (cpu_req || ext_req) begin
                if (cpu_req && ext_req) m_owner = 1 - m_last;
                else m_owner = ext_req ? 1 : 0;
                m_we    = (m_owner == 1) ? ext_we : cpu_we;
                m_addr  = (m_owner == 1) ? ext_addr : cpu_addr;
                m_wdata = (m_owner == 1) ? ext_wdata : cpu_wdata;
                m_last  = m_owner;
                m_busy  = 1;
                m_wait  = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory behind the MIPS core.
- Shares the memory between the core's data port (port 0) and an external loader/debug port (port 1).
- Arbitrates round-robin, runs a req/ready handshake with the memory, returns one-cycle acks and registered read data.
- Drives cpu_stall so the core holds its pipeline while its access is pending.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 16, cycles to wait for mem_ready before aborting; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset; 0 clears all state immediately.
- cpu_req  in  1  core data access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  core byte address.
- cpu_wdata  in  DW  core write data.
- cpu_ack  out  1  one-cycle completion pulse to the core.
- cpu_rdata  out  DW  read data, valid while cpu_ack = 1.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata  same as the cpu_* ports, for the external port.
- mem_req  out  1  memory access strobe, held until mem_ready.
- mem_we  out  1  write enable of the latched request.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data, sampled when mem_ready = 1.
- mem_ready  in  1  memory completion; may assert in the first mem_req cycle.
- err  out  1  pulses with ack on an aborted access (tied 0 without the optional feature).

Behaviour:
- FSM states: IDLE, ACCESS, ACK.
- Reset values: state = IDLE, last_grant = 1 (port 0 wins the first tie), all acks = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata registers = 0, err = 0.
- IDLE, no req: stay in IDLE.
- IDLE, only one req: grant that port.
- IDLE, both req: grant the port != last_grant.
- IDLE grant action (on the edge): latch that port's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_req = 1, update last_grant, go to ACCESS.
- ACCESS: mem_req stays 1 and latched fields stay stable.
- ACCESS, mem_ready = 1 on the edge: capture mem_rdata into the granted port's rdata register (writes capture as well; the value is don't-care), set that port's ack = 1, mem_req = 0, go to ACK.
- ACK: ack high for exactly this cycle, then return to IDLE; ack deasserts on that edge.
- req is ignored in ACK and ACCESS. A requester still asserting req in the IDLE cycle after its ack starts a new transaction.
- The non-granted port's ack stays 0 and its rdata holds its previous value.
- Latency with a zero-wait memory: req at edge 0, mem_req from edge 1, ack during cycle 2, IDLE at edge 3. One transaction per 3 cycles minimum.
- Input changes on the granted port during ACCESS do not affect mem_* outputs.
- Reset asserted mid-transaction: mem_req and ack drop asynchronously, the in-flight access is abandoned with no ack, and last_grant returns to 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0: abort, drop mem_req, go to ACK with the granted ack = 1, err = 1, rdata = 32'hDEADBEEF.
  - mem_ready arriving on the same edge as the timeout wins: normal completion, err = 0.
- Not defined: no counter; ACCESS waits indefinitely; err is tied to 0.

Decomposition:
- Shared package mips_pkg holds the state encodings (IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2), the port indices PORT_CPU = 0 and PORT_EXT = 1, and the abort pattern 32'hDEADBEEF.
- One natural sub-module, rr_pick2: a combinational two-way round-robin chooser taking req[1:0] and last_grant and returning grant_valid and grant_idx.

Test Plan:
- After reset release, cpu read at addr 0x10 with mem_ready tied 1 and mem_rdata = 0x12345678 -> mem_req high for 1 cycle, cpu_ack during the 3rd cycle, cpu_rdata = 0x12345678, cpu_stall low in that same cycle.
- cpu and ext both req in the same cycle (writes to 0x20 / 0x24) -> cpu served first, then ext; mem_addr sequence 0x20, 0x24; with both req held continuously, grants alternate cpu/ext.
- ext write with mem_ready delayed 5 cycles -> mem_req high for 6 cycles, mem_addr/mem_wdata stable even while ext_addr toggles, ext_ack 1 cycle after mem_ready, cpu_stall high for the whole period if cpu_req is asserted.
- Reset driven low during ACCESS -> mem_req and acks drop before the next clock edge; after release, a tie goes to cpu.
- ARB_TIMEOUT_EN, TIMEOUT = 16, mem_ready never asserted -> ack plus err after 16 ACCESS cycles, rdata = 0xDEADBEEF.
- ARB_TIMEOUT_EN with mem_ready asserted in the timeout cycle -> normal ack, err = 0.
